gmux_switch: RTL
================

# gmux_switch

Glitch-free source-select controller for the global clock multiplexer cells. It drives the per-channel select enables (IS0) of NUM_CH global mux cells so that at most one channel is enabled at any time. On a switch request it guarantees a programmable all-off gap before enabling the new channel, then acknowledges. It sits in the clock-network fabric between user control logic and the array of global mux cells, and runs on a free-running control clock.

## Interface

Parameters:
- NUM_CH, 5: number of global mux channels controlled; legal range 2..32.
- GAP_CYCLES, 2: number of QCK cycles all enables are held low between switching channels; legal range 1..255.
- RESET_CH, 0: channel enabled out of reset; must be < NUM_CH.
- SEL_W, derived: max(1, clog2(NUM_CH)); not to be overridden.

Ports:
- QCK  input  1  control clock, rising-edge.
- QRT  input  1  reset, synchronous, active-high.
- REQ  input  1  switch request; sampled only in IDLE.
- SEL  input  SEL_W  requested channel; sampled with REQ.
- PARK  input  1  sampled with REQ; 1 requests all channels off (SEL ignored).
- IS  output  NUM_CH  per-channel enables to the mux IS0 pins; registered, one-hot or zero.
- CUR  output  SEL_W  index of the last enabled channel.
- ACTIVE  output  1  1 when a channel is enabled (IS != 0) and not switching.
- BUSY  output  1  1 while a switch is in progress.
- ACK  output  1  one-cycle pulse on request completion.
- ERR  output  1  one-cycle pulse on a rejected request.

## Operation

- All outputs are registered. Reset values: IS = one-hot(RESET_CH), CUR = RESET_CH, ACTIVE = 1, BUSY = 0, ACK = 0, ERR = 0, state = IDLE, gap counter = 0.
- States: IDLE, DRAIN, ARM.
- IDLE: when REQ = 1, SEL and PARK are latched. Decode is in priority order:
  - PARK = 1: go to DRAIN with the target "none".
  - SEL >= NUM_CH: ERR pulses; no state change; no ACK.
  - SEL == CUR and ACTIVE = 1: ACK pulses; IS unchanged; stay IDLE.
  - Otherwise: go to DRAIN with the target SEL.
- DRAIN:
  - IS = 0, BUSY = 1, ACTIVE = 0.
  - The counter loads GAP_CYCLES - 1 on entry and decrements each cycle.
  - When the counter reaches 0, go to ARM.
- ARM (single cycle, transition only):
  - The next-cycle outputs are IS = one-hot(target), or 0 for a park. CUR = target; CUR is unchanged for a park.
  - ACTIVE = !park, BUSY = 0, ACK = 1. Return to IDLE.
- REQ while BUSY = 1 is ignored and not queued. The requester must re-issue it after ACK.
- Requesting a switch from the parked state (ACTIVE = 0) still runs the full DRAIN.
- IS must never have more than one bit set in any cycle, including the cycles around reset assertion and deassertion.
- QRT asserted in any state, including mid-DRAIN: the next cycle shows the reset values, and the pending request is dropped with no ACK.
- Out-of-range PARK=0 requests never disturb IS.

## Timing

- REQ sampled high at edge t (IDLE, valid switch):
  - IS = 0 and BUSY = 1 from t+1 through t+GAP_CYCLES.
  - From t+GAP_CYCLES+1: IS = new one-hot, CUR updated, ACK = 1 for exactly that one cycle, BUSY = 0.
- Same-channel request: ACK at t+1; no other output changes.
- Invalid request: ERR at t+1; nothing else changes.
- The earliest next accepted REQ is at the edge where ACK is high, i.e. back-to-back requests are legal.
- Total switch latency: GAP_CYCLES + 1 cycles from the REQ edge to the ACK.

## Test plan

- Reset: assert QRT for 2 cycles with NUM_CH=5, RESET_CH=0. Required: IS=5'b00001, CUR=0, ACTIVE=1, BUSY/ACK/ERR=0.
- Switch 0->3, GAP_CYCLES=2: REQ=1, SEL=3 at cycle 10. Required:
  - IS=0 and BUSY=1 at cycles 11-12.
  - IS=5'b01000, CUR=3, ACK=1 at cycle 13 only.
- Same-channel and invalid requests:
  - SEL=CUR: ACK at t+1, IS stable.
  - SEL=6 with NUM_CH=5: ERR at t+1, IS stable, no ACK.
- Park then resume:
  - PARK=1: IS=0 from t+1, ACK at t+3, ACTIVE=0, CUR unchanged.
  - Then SEL=1: IS=0 for 2 cycles, then 5'b00010 with ACK.
- Busy and reset mid-operation:
  - A REQ during DRAIN is ignored, with no extra ACK.
  - QRT at the first DRAIN cycle: the next cycle shows IS=one-hot(RESET_CH) and no ACK.
- Continuous checker across randomised requests with GAP_CYCLES=1 and 7:
  - popcount(IS) <= 1 in every cycle.
  - The IS=0 gap before each new channel is >= GAP_CYCLES cycles.
  - Exactly one ACK or ERR for each accepted REQ.

Source files
------------

// File: rtl/gmux_switch.sv
// Glitch-free source-select controller for the global clock mux cells.
// Keeps at most one IS enable high and inserts an all-off gap on every switch.
module gmux_switch #(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned RESET_CH   = 0,
    parameter int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              QCK,
    input  logic              QRT,
    input  logic              REQ,
    input  logic [SEL_W-1:0]  SEL,
    input  logic              PARK,
    output logic [NUM_CH-1:0] IS,
    output logic [SEL_W-1:0]  CUR,
    output logic              ACTIVE,
    output logic              BUSY,
    output logic              ACK,
    output logic              ERR
);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StArm
    } state_t;

    localparam logic [7:0]        GapLoad = 8'(GAP_CYCLES - 1);
    localparam logic [NUM_CH-1:0] ResetIs = NUM_CH'(1) << RESET_CH;
    localparam logic [SEL_W-1:0]  ResetCh = SEL_W'(RESET_CH);

    state_t           state;
    logic [7:0]       gap_cnt;
    logic [SEL_W-1:0] tgt;
    logic             tgt_park;
    logic             sel_oob;
    logic             same_ch;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

    assign sel_oob = 32'(SEL) >= NUM_CH;
    assign same_ch = (SEL == CUR) && ACTIVE;

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state    <= StIdle;
            gap_cnt  <= 8'd0;
            tgt      <= ResetCh;
            tgt_park <= 1'b0;
            IS       <= ResetIs;
            CUR      <= ResetCh;
            ACTIVE   <= 1'b1;
            BUSY     <= 1'b0;
            ACK      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ACK <= 1'b0;
            ERR <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (REQ) begin
                        if (PARK || (!sel_oob && !same_ch)) begin
                            tgt_park <= PARK;
                            if (!PARK) begin
                                tgt <= SEL;
                            end
                            IS      <= '0;
                            ACTIVE  <= 1'b0;
                            BUSY    <= 1'b1;
                            gap_cnt <= GapLoad;
                            // The ARM cycle itself is the last all-off gap cycle.
                            state   <= (GAP_CYCLES == 1) ? StArm : StDrain;
                        end else if (sel_oob) begin
                            ERR <= 1'b1;
                        end else begin
                            ACK <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state <= StArm;
                    end
                end
                StArm: begin
                    IS     <= tgt_park ? '0 : onehot(tgt);
                    ACTIVE <= !tgt_park;
                    if (!tgt_park) begin
                        CUR <= tgt;
                    end
                    BUSY  <= 1'b0;
                    ACK   <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    a_is_onehot0: assert property (@(posedge QCK) disable iff (QRT) $onehot0(IS));
    a_ack_err_excl: assert property (@(posedge QCK) disable iff (QRT) !(ACK && ERR));
    a_busy_off: assert property (@(posedge QCK) disable iff (QRT) !(BUSY && (IS != '0)));

endmodule
